// File: rtl/ula_muldiv_seq_pkg.sv
// Shared constants for the multiply/divide sequencer: ULA opcodes, md_op encodings,
// the sequencer state enum and the radix-2 iteration count.
package ula_muldiv_seq_pkg;

  localparam logic [4:0] ULA_NOP = 5'b00000;
  localparam logic [4:0] ULA_ADD = 5'b00010;
  localparam logic [4:0] ULA_SUB = 5'b00110;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam int ITER_CNT = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_FIX_LO, S_FIX_HI, S_DONE
  } state_e;

endpackage

// File: rtl/ula_muldiv_seq.sv
// MULT/MULTU/DIV/DIVU sequencer owning HI/LO; borrows the shared ULA for all add/sub work.
// ULA_MULDIV_DIV_EN enables the restoring divider; without it DIV/DIVU complete at once as no-ops.
module ula_muldiv_seq
  import ula_muldiv_seq_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        ula_own,
  output logic [31:0] ula_a,
  output logic [31:0] ula_b,
  output logic [4:0]  ula_op,
  input  logic [31:0] ula_s
);

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sa_q, sa_d, sb_q, sb_d;
`ifdef ULA_MULDIV_DIV_EN
  logic        div_q, div_d;
  logic [31:0] rem_sh;
  logic        take;
`endif
  logic [31:0] addend;
  logic        carry;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
`ifdef ULA_MULDIV_DIV_EN
      div_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
`ifdef ULA_MULDIV_DIV_EN
      div_q   <= div_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
`ifdef ULA_MULDIV_DIV_EN
    div_d   = div_q;
    rem_sh  = '0;
    take    = 1'b0;
`endif
    addend  = '0;
    carry   = 1'b0;
    ula_a   = '0;
    ula_b   = '0;
    ula_op  = ULA_NOP;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_NEG_A;
          hi_d    = '0;
          lo_d    = op_a;
          b_d     = op_b;
          sa_d    = ~md_op[0] & op_a[31];
          sb_d    = ~md_op[0] & op_b[31];
          cnt_d   = '0;
`ifdef ULA_MULDIV_DIV_EN
          div_d   = md_op[1];
          if (md_op[1] && op_b == 32'd0) begin
            state_d = S_DONE;
            hi_d    = op_a;
            lo_d    = '1;
          end
`else
          if (md_op[1]) begin
            state_d = S_DONE;
            hi_d    = hi_q;
            lo_d    = lo_q;
          end
`endif
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_NEG_A: begin
        state_d = S_NEG_B;
        if (sa_q) begin
          ula_b  = lo_q;
          ula_op = ULA_SUB;
          lo_d   = ula_s;
        end
      end
      S_NEG_B: begin
        state_d = S_ITER;
        if (sb_q) begin
          ula_b  = b_q;
          ula_op = ULA_SUB;
          b_d    = ula_s;
        end
      end
      S_ITER: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER_CNT - 1)) state_d = S_FIX_LO;
`ifdef ULA_MULDIV_DIV_EN
        if (div_q) begin
          // hi[31] set means the shifted remainder is 33 bits wide and always exceeds |B|
          rem_sh = {hi_q[30:0], lo_q[31]};
          ula_a  = rem_sh;
          ula_b  = b_q;
          ula_op = ULA_SUB;
          take   = hi_q[31] | (rem_sh >= b_q);
          hi_d   = take ? ula_s : rem_sh;
          lo_d   = {lo_q[30:0], take};
        end else
`endif
        begin
          addend = lo_q[0] ? b_q : 32'd0;
          ula_a  = hi_q;
          ula_b  = addend;
          ula_op = ULA_ADD;
          carry  = ula_s < addend;
          hi_d   = {carry, ula_s[31:1]};
          lo_d   = {ula_s[0], lo_q[31:1]};
        end
      end
      S_FIX_LO: begin
        state_d = S_FIX_HI;
        if (sa_q ^ sb_q) begin
          ula_b  = lo_q;
          ula_op = ULA_SUB;
          lo_d   = ula_s;
        end
      end
      S_FIX_HI: begin
        state_d = S_DONE;
`ifdef ULA_MULDIV_DIV_EN
        if (div_q) begin
          if (sa_q) begin
            ula_b  = hi_q;
            ula_op = ULA_SUB;
            hi_d   = ula_s;
          end
        end else
`endif
        // lo is already negated here; negation preserves zero, so it still tells us the borrow
        if (sa_q ^ sb_q) begin
          ula_a  = ~hi_q;
          ula_b  = {31'd0, lo_q == 32'd0};
          ula_op = ULA_ADD;
          hi_d   = ula_s;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign ula_own = busy;
  assign done    = (state_q == S_DONE);
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule
